// File: rtl/alu_issue.sv
// alu_issue: EX issue register with MEM/WB operand forwarding, load-use stall and valid/ready hold
module alu_issue #(
  parameter int XLEN = 32,
  parameter int OPW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [OPW-1:0]  id_op,
  input  logic [4:0]      id_rs1_idx,
  input  logic [4:0]      id_rs2_idx,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [4:0]      id_rd_idx,
  input  logic            id_rd_we,
  input  logic            mem_fwd_we,
  input  logic [4:0]      mem_fwd_idx,
  input  logic [XLEN-1:0] mem_fwd_val,
  input  logic            mem_is_load,
  input  logic            wb_fwd_we,
  input  logic [4:0]      wb_fwd_idx,
  input  logic [XLEN-1:0] wb_fwd_val,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [4:0]      ex_rd_idx,
  output logic            ex_rd_we,
  output logic [31:0]     stall_cnt
);
  logic hazard, cap;
  logic [XLEN-1:0] rs1_res, rs2_res;
  assign hazard = id_valid && mem_fwd_we && mem_is_load && mem_fwd_idx != 5'd0 &&
                  (mem_fwd_idx == id_rs1_idx || (!id_use_imm && mem_fwd_idx == id_rs2_idx));
  assign id_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign cap = id_valid && id_ready;
  assign rs1_res = id_rs1_idx == 5'd0 ? '0 :
                   (mem_fwd_we && mem_fwd_idx == id_rs1_idx && !mem_is_load) ? mem_fwd_val :
                   (wb_fwd_we && wb_fwd_idx == id_rs1_idx) ? wb_fwd_val : id_rs1_val;
  assign rs2_res = id_use_imm ? id_imm :
                   id_rs2_idx == 5'd0 ? '0 :
                   (mem_fwd_we && mem_fwd_idx == id_rs2_idx && !mem_is_load) ? mem_fwd_val :
                   (wb_fwd_we && wb_fwd_idx == id_rs2_idx) ? wb_fwd_val : id_rs2_val;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      alu_op    <= '0;
      alu_rs1   <= '0;
      alu_rs2   <= '0;
      ex_rd_idx <= '0;
      ex_rd_we  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      ex_valid <= flush ? 1'b0 : cap ? 1'b1 : ex_ready ? 1'b0 : ex_valid;
      if (cap) begin
        alu_op    <= id_op;
        alu_rs1   <= rs1_res;
        alu_rs2   <= rs2_res;
        ex_rd_idx <= id_rd_idx;
        ex_rd_we  <= id_rd_we;
      end
      if (hazard && !flush) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue register sitting directly upstream of the ALU. It accepts a decoded instruction from the decode stage and resolves its operands by forwarding from the MEM and WB stages. It selects the immediate for rs2 when required, detects load-use hazards, and holds the ALU's `op`/`rs1`/`rs2` inputs stable behind a valid/ready handshake with the downstream EX/MEM stage.

## Interface
- `XLEN`, 32, operand/result width
- `OPW`, 4, ALU opcode width (matches the ALU `op` port)
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `id_valid` input 1: decode presents an instruction
- `id_ready` output 1: issue register accepts this cycle
- `id_op` input OPW: ALU opcode
- `id_rs1_idx`, `id_rs2_idx` input 5 each: source register indices
- `id_rs1_val`, `id_rs2_val` input XLEN each: register-file read data
- `id_imm` input XLEN: sign-extended immediate
- `id_use_imm` input 1: rs2 operand = `id_imm`, rs2 hazard/forward ignored
- `id_rd_idx` input 5, `id_rd_we` input 1: destination register and write enable
- `mem_fwd_we` input 1, `mem_fwd_idx` input 5, `mem_fwd_val` input XLEN: EX/MEM result bypass
- `mem_is_load` input 1: MEM-stage instruction is a load whose data is not yet available
- `wb_fwd_we` input 1, `wb_fwd_idx` input 5, `wb_fwd_val` input XLEN: writeback bypass
- `flush` input 1: kill the held instruction and any capture this cycle
- `ex_valid` output 1, `ex_ready` input 1: handshake to EX/MEM
- `alu_op` output OPW, `alu_rs1` output XLEN, `alu_rs2` output XLEN: drive the ALU directly
- `ex_rd_idx` output 5, `ex_rd_we` output 1: destination carried alongside
- `stall_cnt` output 32: count of load-use stall cycles

## Operation
- Operand selection per source at capture, priority high→low:
  - index 0: value 0, never forwarded
  - `mem_fwd_we && mem_fwd_idx==idx && !mem_is_load`: `mem_fwd_val`
  - `wb_fwd_we && wb_fwd_idx==idx`: `wb_fwd_val`
  - otherwise the register-file value
- rs2 is `id_imm` when `id_use_imm`=1.
- Load-use hazard: `id_valid && mem_fwd_we && mem_is_load && mem_fwd_idx!=0 && (mem_fwd_idx==id_rs1_idx || (!id_use_imm && mem_fwd_idx==id_rs2_idx))`.
- `id_ready = (!ex_valid || ex_ready) && !hazard && !flush` (combinational).
- Capture (`id_valid && id_ready`): latch op, resolved operands, `rd_idx`, `rd_we`; `ex_valid`←1.
- No capture with `ex_valid && ex_ready`: `ex_valid`←0. Payload registers hold their last value.
- `ex_valid && !ex_ready`: all outputs hold stable, and `id_ready`=0.
- `flush`: `ex_valid`←0 next cycle, regardless of `ex_ready`/`id_valid`. Flush wins over capture.
- Operands are resolved once, at capture. A held instruction is never re-forwarded; older producers are already downstream.
- `stall_cnt` increments by 1 each cycle that hazard=1 and `flush`=0. It wraps at 2^32−1→0.
- There is no state machine beyond `ex_valid`: EMPTY (`ex_valid`=0) / FULL (`ex_valid`=1).

## Timing
- Reset, asynchronous: `ex_valid`=0, `alu_op`=0, `alu_rs1`=0, `alu_rs2`=0, `ex_rd_idx`=0, `ex_rd_we`=0, `stall_cnt`=0. While in reset, `id_ready` evaluates to 1 (`ex_valid`=0) but no capture occurs.
- Latency: one cycle from accepted `id_valid` to `ex_valid`=1 with operands on the ALU.
- Full throughput: back-to-back captures are allowed when `ex_ready`=1 (simultaneous drain and fill).
- Reset asserted mid-stall or mid-hold: the instruction is lost, and `stall_cnt` clears.
- Hazard persists for exactly as long as `mem_is_load` stays asserted for the matching index. Capture happens the first cycle it drops, with WB forwarding then supplying the value if the load has moved to WB.

## Test plan
- Reset then single issue: `id_op`=ADD, rs1=x1 (val 5), rs2=x2 (val 7), `ex_ready`=1 → next cycle `ex_valid`=1, `alu_rs1`=5, `alu_rs2`=7; the following cycle `ex_valid`=0.
- Forward priority: rs1=x3, mem fwd x3=0x11, wb fwd x3=0x22, RF=0x33 → `alu_rs1`=0x11. Drop mem fwd → 0x22. x0 with both forwards matching idx 0 → 0.
- Load-use stall: `mem_is_load`=1, `mem_fwd_idx`=4, rs1=x4 for 3 cycles → `id_ready`=0 for 3 cycles and `stall_cnt`=3. Then `mem_is_load`=0 with wb fwd x4=0xABCD → capture, `alu_rs1`=0xABCD.
- Immediate: `id_use_imm`=1, rs2=x4 matches pending load, `id_imm`=0xFFFFFFF0 → no stall, `alu_rs2`=0xFFFFFFF0.
- Backpressure: hold `ex_ready`=0 for 4 cycles with a new `id_valid` waiting → outputs unchanged, `id_ready`=0. Release → the new instruction is captured the same cycle, with no bubble.
- Flush with `id_valid`=1, `ex_valid`=1, `ex_ready`=0 → next cycle `ex_valid`=0, no capture. Assert `rst` during a stall → all outputs and `stall_cnt` are 0 immediately.
